// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier:
// FSM state encoding and operand-mode selectors.
package mult_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle for seq_mult. The master drives operands
// and consumes products; the slave is the multiplier.
interface seq_mult_if #(parameter int WIDTH = 4);

  logic                   abort;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output abort, in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  abort, in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/mult_addsub.sv
// N-bit ripple-carry adder/subtractor; subtract inverts y and injects a
// carry-in of one. The carry out of the top bit is discarded.
module mult_addsub #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] result
);

  logic [N-1:0] w_y;
  logic [N-1:0] w_c;

  assign w_y    = y ^ {N{sub}};
  assign w_c[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign result[i] = x[i] ^ w_y[i] ^ w_c[i];
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or
// signed two's-complement per operation, valid/ready on both sides.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sgn;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic             w_last;
  logic             w_sub;
  logic             w_accept;
  logic             w_step;

  assign w_last   = (r_cnt == CNT_LAST);
  assign w_ext    = (r_sgn == MODE_SIGNED) ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
  assign w_addend = r_q[0] ? w_ext : {(WIDTH+1){1'b0}};
  // The signed multiplier's MSB carries weight -2^(W-1), so its partial product is subtracted.
  assign w_sub    = (r_sgn == MODE_SIGNED) && w_last;
  assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.abort;
  assign w_step   = (r_state == BUSY) && !bus.abort;

  mult_addsub #(.N(WIDTH + 1)) u_addsub (
    .x      (r_acc),
    .y      (w_addend),
    .sub    (w_sub),
    .result (w_sum)
  );

  // Next-state decode; abort overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) w_state_nxt = BUSY;
          else              w_state_nxt = IDLE;
        end
        BUSY: begin
          if (w_last) w_state_nxt = DONE;
          else        w_state_nxt = BUSY;
        end
        DONE: begin
          if (bus.out_ready) w_state_nxt = IDLE;
          else               w_state_nxt = DONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch, accumulator/multiplier shift pair and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= {WIDTH{1'b0}};
      r_q   <= {WIDTH{1'b0}};
      r_acc <= {(WIDTH+1){1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_sgn <= MODE_UNSIGNED;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_q   <= bus.b;
      r_acc <= {(WIDTH+1){1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_sgn <= bus.is_signed ? MODE_SIGNED : MODE_UNSIGNED;
    end else if (w_step) begin
      r_acc <= {(r_sgn == MODE_SIGNED) ? w_sum[WIDTH] : 1'b0, w_sum[WIDTH:1]};
      r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.product   = {r_acc[WIDTH-1:0], r_q};

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult at WIDTH = 4.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_mult_if #(.WIDTH(4)) bus ();

  seq_mult #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] p;
    ex = s ? {{4{x[3]}}, x} : {4'h0, x};
    ey = s ? {{4{y[3]}}, y} : {4'h0, y};
    p  = ex * ey;
    return p;
  endfunction

  // One full operation: accept, wait (bounded) for the result, check, retire.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic s,
                        input logic [7:0] exp, input string tag);
    int lat;
    chk({tag, " in_ready"}, {15'd0, bus.in_ready}, 16'd1);
    bus.a = x; bus.b = y; bus.is_signed = s; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 16'(lat), 16'd4);
    chk({tag, " product"}, {8'h00, bus.product}, {8'h00, exp});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " retire"}, {15'd0, bus.in_ready}, 16'd1);
  endtask

  initial begin
    logic [3:0] pa [4];
    logic [3:0] pb [4];
    logic [7:0] pe [4];
    int         p_idx;
    int         r_idx;
    int         last_c;
    logic       seen;

    rst_n = 1'b0;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.a = 4'h0; bus.b = 4'h0;
    bus.is_signed = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("rst in_ready",  {15'd0, bus.in_ready},  16'd1);
    chk("rst out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst product",   {8'h00, bus.product},   16'h0000);
    rst_n = 1'b1;
    tick();

    run_op(4'hF, 4'hF, 1'b0, 8'hE1, "u F*F");
    run_op(4'hB, 4'h3, 1'b0, 8'h21, "u B*3");
    run_op(4'h8, 4'h8, 1'b1, 8'h40, "s 8*8");
    run_op(4'h8, 4'h7, 1'b1, 8'hC8, "s 8*7");
    run_op(4'h3, 4'hB, 1'b1, 8'hF1, "s 3*B");
    run_op(4'h0, 4'h8, 1'b1, 8'h00, "s 0*8");

    // Backpressure: result must hold while out_ready stays low.
    bus.a = 4'h5; bus.b = 4'h6; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp first valid", {15'd0, bus.out_valid}, 16'd1);
    chk("bp product", {8'h00, bus.product}, 16'h001E);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp hold valid",   {15'd0, bus.out_valid}, 16'd1);
      chk("bp hold product", {8'h00, bus.product},   16'h001E);
      chk("bp hold ready",   {15'd0, bus.in_ready},  16'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp release ready", {15'd0, bus.in_ready},  16'd1);
    chk("bp release valid", {15'd0, bus.out_valid}, 16'd0);

    // Abort during the second BUSY cycle.
    bus.a = 4'h7; bus.b = 4'h7; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort ready", {15'd0, bus.in_ready},  16'd1);
    chk("abort valid", {15'd0, bus.out_valid}, 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort no result", {15'd0, seen}, 16'd0);
    run_op(4'h2, 4'h3, 1'b0, 8'h06, "post-abort 2*3");

    // Asynchronous reset mid-BUSY, between clock edges.
    bus.a = 4'hF; bus.b = 4'hF; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst in_ready",  {15'd0, bus.in_ready},  16'd1);
    chk("arst out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst product",   {8'h00, bus.product},   16'h0000);
    #2 rst_n = 1'b1;
    tick();
    run_op(4'h9, 4'h9, 1'b1, 8'h31, "post-rst s 9*9");

    // Back-to-back with in_valid held high; junk operands outside IDLE.
    pa[0] = 4'h3; pb[0] = 4'h5; pe[0] = 8'h0F;
    pa[1] = 4'hA; pb[1] = 4'hC; pe[1] = 8'h78;
    pa[2] = 4'h7; pb[2] = 4'h9; pe[2] = 8'h3F;
    pa[3] = 4'hE; pb[3] = 4'h2; pe[3] = 8'h1C;
    p_idx = 0; r_idx = 0; last_c = 0;
    bus.out_ready = 1'b1; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid && r_idx < 4) begin
        chk("b2b product", {8'h00, bus.product}, {8'h00, pe[r_idx]});
        if (r_idx > 0) chk("b2b spacing", 16'(c - last_c), 16'd6);
        last_c = c;
        r_idx++;
      end
      if (bus.in_ready && p_idx < 4) begin
        bus.a = pa[p_idx]; bus.b = pb[p_idx];
        p_idx++;
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.a = 4'hF; bus.b = 4'hF;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b result count", 16'(r_idx), 16'd4);
    chk("b2b idle", {15'd0, bus.in_ready}, 16'd1);

    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          run_op(4'(x), 4'(y), 1'(s), ref_mul(4'(x), 4'(y), 1'(s)), "sweep");
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
